rgb_pwm_fader: RTL and testbench

- Drives the OrangeCrab RGB LED pins (rgb_led0_r/g/b, active-low) with PWM from three 8-bit colour levels.
- Accepts new target colours on a valid/ready handshake.
- Ramps each channel linearly from its current level to the target, one step per fade interval.
- Sits directly upstream of the LED pins and replaces simple counter-bit blinking; colour sources such as sequencers and USB registers feed it.

---
 rtl/rgb_pwm_fader.sv | 133 +++++++++++++
 tb/tb_rgb_pwm_fader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: three-channel PWM driver for the active-low OrangeCrab RGB LED.
// Accepts target colours on a valid/ready handshake. Each channel then ramps
// one LSB toward its target every FADE_TICKS PWM periods.
module rgb_pwm_fader #(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 188,
  parameter int FADE_TICKS = 4
) (
  input  logic                clk48,
  input  logic                rst,
  input  logic                color_valid,
  output logic                color_ready,
  input  logic [PWM_BITS-1:0] color_r,
  input  logic [PWM_BITS-1:0] color_g,
  input  logic [PWM_BITS-1:0] color_b,
  output logic                busy,
  output logic                rgb_led0_r,
  output logic                rgb_led0_g,
  output logic                rgb_led0_b
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FADE_W = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_TICKS - 1);

  typedef enum logic {IDLE, FADE} state_t;

  // Channel index 0 = red, 1 = green, 2 = blue throughout.
  logic [2:0][PWM_BITS-1:0] col_in;
  logic [2:0][PWM_BITS-1:0] cur_q, cur_d;
  logic [2:0][PWM_BITS-1:0] tgt_q, tgt_d;
  logic [PRE_W-1:0]         pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [FADE_W-1:0]        fade_cnt_q, fade_cnt_d;
  state_t                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic [2:0]               led_q, led_d;
  logic [2:0]               lit;
  logic                     tick;
  logic                     period_end;
  logic                     all_eq;

  assign col_in     = {color_b, color_g, color_r};
  assign tick       = (pre_cnt_q == PRE_LAST);
  assign period_end = tick && (pwm_cnt_q == {PWM_BITS{1'b1}});
  assign all_eq     = (cur_q == tgt_q);

  // Per-channel PWM comparator: lit while the counter is below the level.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign lit[gi] = (pwm_cnt_q < cur_q[gi]);
    end
  endgenerate

  // Next-state logic: counters, handshake/fade FSM, level stepping, LED drive.
  always_comb begin
    pre_cnt_d  = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    state_d    = state_q;
    fade_cnt_d = fade_cnt_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    case (state_q)
      IDLE: begin
        // ready is high in IDLE, so valid alone completes the handshake.
        if (color_valid) begin
          tgt_d      = col_in;
          fade_cnt_d = '0;
          state_d    = FADE;
        end
      end
      FADE: begin
        // Levels only move at period boundaries so a period never glitches.
        if (period_end) begin
          if (fade_cnt_q == FADE_LAST) begin
            fade_cnt_d = '0;
            for (int i = 0; i < 3; i++) begin
              if (cur_q[i] < tgt_q[i]) begin
                cur_d[i] = cur_q[i] + 1'b1;
              end else if (cur_q[i] > tgt_q[i]) begin
                cur_d[i] = cur_q[i] - 1'b1;
              end
            end
          end else begin
            fade_cnt_d = fade_cnt_q + 1'b1;
          end
        end
        if (all_eq) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == FADE);
    led_d   = ~lit;
  end

  // State registers with synchronous reset; LEDs reset dark (high).
  always_ff @(posedge clk48) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      cur_q      <= '0;
      tgt_q      <= '0;
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      led_q      <= 3'b111;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      state_q    <= state_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      led_q      <= led_d;
    end
  end

  assign color_ready = ready_q;
  assign busy        = busy_q;
  assign rgb_led0_r  = led_q[0];
  assign rgb_led0_g  = led_q[1];
  assign rgb_led0_b  = led_q[2];

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: scoreboard bench for rgb_pwm_fader with a small PWM period.
// The stimulus side pushes expected fade length and final levels on each
// accepted colour. The monitor pops one entry whenever busy falls, then checks
// one full period of LED duty.
module tb_rgb_pwm_fader;

  localparam int P   = 2;
  localparam int B   = 4;
  localparam int F   = 1;
  localparam int PER = P * (1 << B);

  logic         clk48 = 1'b0;
  logic         rst = 1'b1;
  logic         color_valid = 1'b0;
  logic [B-1:0] color_r = '0;
  logic [B-1:0] color_g = '0;
  logic [B-1:0] color_b = '0;
  logic         color_ready;
  logic         busy;
  logic         rgb_led0_r, rgb_led0_g, rgb_led0_b;

  typedef struct {
    int len;
    int r;
    int g;
    int b;
    bit meas;
  } exp_t;

  exp_t sb[$];
  int   lvl[3];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  rgb_pwm_fader #(.PWM_BITS(B), .PRESCALE(P), .FADE_TICKS(F)) dut (
    .clk48(clk48), .rst(rst), .color_valid(color_valid), .color_ready(color_ready),
    .color_r(color_r), .color_g(color_g), .color_b(color_b), .busy(busy),
    .rgb_led0_r(rgb_led0_r), .rgb_led0_g(rgb_led0_g), .rgb_led0_b(rgb_led0_b)
  );

  always #5 clk48 = ~clk48;

  // Cycles since the last reset edge; equals the DUT's free-running tick phase.
  always @(posedge clk48) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Busy length in cycles for a fade of d steps accepted in cycle ka.
  // Steps land on edges at multiples of PER, the first one at least two cycles
  // after acceptance; busy ends one cycle after the last step.
  function automatic int exp_len(input int ka, input int d);
    int e1;
    if (d == 0) return 1;
    e1 = ((ka + 2 + PER - 1) / PER) * PER;
    return e1 + PER * (F * d - 1) - ka;
  endfunction

  // Present a colour, hold it until accepted, and record the expectation.
  task automatic send(input int r, input int g, input int b, input bit meas, input bit hold_chk);
    bit   done;
    int   d;
    exp_t e;
    done = 1'b0;
    @(posedge clk48);
    #1;
    color_r = B'(r);
    color_g = B'(g);
    color_b = B'(b);
    color_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk48);
      if (hold_chk && i == 0) check("bp_ready_low", color_ready, 0);
      if (color_ready) begin
        d = iabs(r - lvl[0]);
        if (iabs(g - lvl[1]) > d) d = iabs(g - lvl[1]);
        if (iabs(b - lvl[2]) > d) d = iabs(b - lvl[2]);
        e.len = exp_len(cyc, d);
        e.r = r;
        e.g = g;
        e.b = b;
        e.meas = meas;
        sb.push_back(e);
        lvl[0] = r;
        lvl[1] = g;
        lvl[2] = b;
        done = 1'b1;
      end
    end
    check("send_accepted", done, 1);
    @(posedge clk48);
    #1;
    color_valid = 1'b0;
  endtask

  // Wait (bounded) for the fade to end, then leave room for the duty window.
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < PER * (16 * F + 4) && !ok; i++) begin
      @(negedge clk48);
      if (!busy) ok = 1'b1;
    end
    check("done_in_time", ok, 1);
    repeat (PER + 8) @(negedge clk48);
  endtask

  // Monitor: busy length and post-fade LED duty against the scoreboard.
  initial begin
    int   blen;
    bit   pb;
    bit   measuring;
    int   mcnt;
    int   lows[3];
    exp_t e;
    blen = 0;
    pb = 1'b0;
    measuring = 1'b0;
    mcnt = 0;
    lows = '{0, 0, 0};
    e = '{0, 0, 0, 0, 1'b0};
    forever begin
      @(negedge clk48);
      if (rst) begin
        sb.delete();
        blen = 0;
        pb = 1'b0;
        measuring = 1'b0;
      end else begin
        check("ready_vs_busy", color_ready, busy ? 0 : 1);
        if (busy) begin
          blen++;
        end else if (pb) begin
          if (sb.size() == 0) begin
            check("unexpected_done_qsize", 0, 1);
          end else begin
            e = sb.pop_front();
            check("busy_len", blen, e.len);
            if (e.meas) begin
              measuring = 1'b1;
              mcnt = 0;
              lows = '{0, 0, 0};
            end
          end
          blen = 0;
        end
        if (measuring) begin
          if (!rgb_led0_r) lows[0]++;
          if (!rgb_led0_g) lows[1]++;
          if (!rgb_led0_b) lows[2]++;
          mcnt++;
          if (mcnt == PER) begin
            check("duty_r", lows[0], P * e.r);
            check("duty_g", lows[1], P * e.g);
            check("duty_b", lows[2], P * e.b);
            measuring = 1'b0;
          end
        end
        pb = busy;
      end
    end
  end

  // Watchdog: the bench must never hang.
  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus sequence.
  initial begin
    lvl = '{0, 0, 0};
    rst = 1'b1;
    repeat (3) @(posedge clk48);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk48);
      check("idle_leds", {rgb_led0_r, rgb_led0_g, rgb_led0_b}, 7);
      check("idle_ready", color_ready, 1);
      check("idle_busy", busy, 0);
    end

    // Fade up red, then mixed fade with blue held.
    send(15, 0, 0, 1, 0);
    wait_done();
    send(15, 0, 8, 1, 0);
    wait_done();
    send(0, 15, 8, 1, 0);
    wait_done();

    // Backpressure: offer (3,3,3) during an active fade and hold it.
    send(12, 2, 15, 0, 0);
    repeat (50) @(negedge clk48);
    send(3, 3, 3, 1, 1);
    wait_done();

    // Equal target: one busy cycle, duty unchanged.
    send(5, 5, 5, 1, 0);
    wait_done();
    send(5, 5, 5, 1, 0);
    wait_done();

    // Reset mid-fade, then a short fade starting from zero.
    send(0, 0, 0, 1, 0);
    wait_done();
    send(15, 0, 0, 1, 0);
    repeat (8 * PER) @(negedge clk48);
    @(posedge clk48);
    #1;
    rst = 1'b1;
    @(posedge clk48);
    #1;
    rst = 1'b0;
    lvl = '{0, 0, 0};
    @(negedge clk48);
    check("rst_leds", {rgb_led0_r, rgb_led0_g, rgb_led0_b}, 7);
    check("rst_busy", busy, 0);
    check("rst_ready", color_ready, 1);
    send(2, 0, 0, 1, 0);
    wait_done();

    // Random targets at random phases.
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, PER)) @(posedge clk48);
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1, 0);
      wait_done();
    end

    repeat (10) @(negedge clk48);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
